// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per cycle, MSD first.
// Optional macro BCD_CHECK_EN adds illegal-digit (>9) detection on err.
`timescale 1ns/1ps
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BW     = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*DIGITS-1:0] bcd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW-1:0]     bin,
  output logic              err
);

  localparam int NW = 4 * DIGITS;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [NW-1:0] r_bcd;
  logic [BW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [3:0]    w_dig;
  logic [BW-1:0] w_acc_nx;
  logic          w_last;
  logic          w_acpt;

  assign w_dig    = r_bcd[NW-1 -: 4];
  assign w_acc_nx = (r_acc << 3) + (r_acc << 1) + BW'(w_dig);
  assign w_last   = (r_cnt == CW'(DIGITS - 1));
  assign w_acpt   = in_valid && (r_state == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: accept in IDLE, DIGITS steps in CONV, hold DONE until taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = CONV;
      CONV:    if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture word, then shift out one digit per cycle into acc*10+d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_acpt) begin
      r_bcd <= bcd;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == CONV) begin
      r_acc <= w_acc_nx;
      r_bcd <= r_bcd << 4;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

`ifdef BCD_CHECK_EN
  logic r_err;

  // Sticky flag for any digit above 9 seen during the current conversion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_err <= 1'b0;
    else if (w_acpt)                     r_err <= 1'b0;
    else if (r_state == CONV && w_dig > 4'd9) r_err <= 1'b1;
  end

  assign err = (r_state == DONE) && r_err;
  assign bin = err ? '0 : r_acc;
`else
  assign err = 1'b0;
  assign bin = r_acc;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: vector table plus handshake/reset sequences.
// Expected err/bin for illegal digits follow BCD_CHECK_EN.
`timescale 1ns/1ps
module tb_bcd_to_bin;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] bin;
  logic        err;

  bcd_to_bin #(.DIGITS(4), .BW(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd       (bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin       (bin),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int   c;
    logic [13:0] b;
    logic e;
  } res_t;

  res_t res_q[$];
  bit   mon_en = 0;

  always @(negedge clk)
    if (mon_en && out_valid)
      res_q.push_back('{c: cyc, b: bin, e: err});

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic [15:0] w, input string nm,
                         input logic [13:0] eb, input logic ee);
    int n;
    chk({nm, " in_ready"}, in_ready, 1);
    bcd      = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, n, 4);
    chk({nm, " bin"}, bin, eb);
    chk({nm, " err"}, err, ee);
    tick();
    chk({nm, " idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  typedef struct {
    logic [15:0] w;
    logic [13:0] b;
    logic        e;
    string       nm;
  } vec_t;

  vec_t vt[8];

  initial begin
    int n;
    vt[0] = '{16'h1234, 14'd1234, 1'b0, "v1234"};
    vt[1] = '{16'h9999, 14'd9999, 1'b0, "v9999"};
    vt[2] = '{16'h0000, 14'd0,    1'b0, "v0000"};
    vt[3] = '{16'h0042, 14'd42,   1'b0, "v0042"};
    vt[4] = '{16'h5678, 14'd5678, 1'b0, "v5678"};
    vt[5] = '{16'h0001, 14'd1,    1'b0, "v0001"};
`ifdef BCD_CHECK_EN
    vt[6] = '{16'h12A4, 14'd0,    1'b1, "v12A4"};
    vt[7] = '{16'hFFFF, 14'd0,    1'b1, "vFFFF"};
`else
    vt[6] = '{16'h12A4, 14'd1304, 1'b0, "v12A4"};
    vt[7] = '{16'hFFFF, 14'd281,  1'b0, "vFFFF"};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    bcd       = 16'h1234;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst bin", bin, 0);
    chk("rst err", err, 0);
    rst_n = 1'b1;

    foreach (vt[i]) convert(vt[i].w, vt[i].nm, vt[i].b, vt[i].e);

    // backpressure
    out_ready = 1'b0;
    bcd       = 16'h0987;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp latency", n, 4);
    bcd      = 16'h5555;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp hold", {out_valid, in_ready, bin},
          {1'b1, 1'b0, 14'd987});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp release", {in_ready, out_valid}, 2'b10);

    // reset two cycles into CONV
    bcd      = 16'h1234;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre-rst bin", bin, 12);
    rst_n = 1'b0;
    #1;
    chk("mid-rst outs", {out_valid, err, bin}, 16'd0);
    chk("mid-rst in_ready", in_ready, 1);
    res_q.delete();
    mon_en = 1'b1;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (6) tick();
    chk("rst no result", res_q.size(), 0);
    mon_en = 1'b0;
    convert(16'h0042, "post-rst", 14'd42, 1'b0);

    // back-to-back with in_valid held
    res_q.delete();
    mon_en   = 1'b1;
    bcd      = 16'h0001;
    in_valid = 1'b1;
    tick();
    bcd = 16'h0010;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("b2b reaccept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    mon_en = 1'b0;
    chk("b2b count", res_q.size(), 2);
    if (res_q.size() == 2) begin
      chk("b2b first", res_q[0].b, 1);
      chk("b2b second", res_q[1].b, 10);
      chk("b2b spacing", res_q[1].c - res_q[0].c, 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of packed BCD digits per input word (legal 1..8).
REQ-002 SHALL have parameter BW, default 14, giving the binary result width; the integrator sets BW >= ceil(log2(10^DIGITS)).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, meaning the bcd word is presented.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept a word.
REQ-007 SHALL have port bcd, input, 4*DIGITS, the packed BCD word; the most significant digit is in the top nibble.
REQ-008 SHALL have port out_valid, output, 1, meaning bin and err are valid.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 SHALL have port bin, output, BW, the binary result.
REQ-011 SHALL have port err, output, 1, the invalid-digit flag.

Function
REQ-012 SHALL implement the FSM states IDLE, CONV and DONE; in_ready SHALL equal (state==IDLE), and out_valid SHALL equal (state==DONE).
REQ-013 On an input transfer (in_valid && in_ready at a rising edge), the block SHALL capture bcd into an internal register, clear the accumulator to 0, clear the digit counter, and go IDLE->CONV; while in_valid is low, IDLE SHALL hold.
REQ-014 In CONV, each cycle SHALL process one digit, MSD first: acc <= acc*10 + digit, with *10 computed as (acc<<3)+(acc<<1) and all arithmetic modulo 2^BW.
REQ-015 After DIGITS CONV cycles, the FSM SHALL go CONV->DONE; out_valid SHALL rise exactly DIGITS clock edges after the accepting edge.
REQ-016 In DONE, bin and err SHALL hold stable until out_ready is high at a rising edge; the FSM SHALL then go DONE->IDLE.
REQ-017 No input SHALL be accepted in CONV or DONE; bcd changes there SHALL not affect the result, because the captured copy is used.
REQ-018 Sustained throughput SHALL be one result per DIGITS+2 cycles when out_ready is held high.
REQ-019 Outside DONE, bin SHALL read the current accumulator value and err SHALL read 0.

Reset
REQ-020 When rst_n is low, the block SHALL immediately force state=IDLE, acc=0, the digit counter to 0, the captured word to 0 and the error flag to 0; out_valid=0, bin=0, err=0 and in_ready=1.
REQ-021 While rst_n is low, in_valid SHALL be ignored.
REQ-022 A reset during CONV or DONE SHALL discard the conversion in progress; no out_valid pulse SHALL follow it.
REQ-023 The first transfer SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-024 With the macro BCD_CHECK_EN defined, any captured digit greater than 9 SHALL set an error flag during CONV, and in DONE the block SHALL present err=1 and bin=0.
REQ-025 With BCD_CHECK_EN undefined, illegal digits SHALL be used at face value in REQ-014 arithmetic, err SHALL be tied to 0, and no checking logic SHALL be synthesised.
REQ-026 Latency and handshake SHALL be identical in both builds.

Verification
REQ-027 Scenario (defaults), conversion: bcd=16'h1234, one-cycle in_valid, out_ready=1 -> out_valid rises 4 edges after accept, bin=1234 (14'h04D2), err=0; one cycle later in_ready=1.
REQ-028 Scenario, extremes: bcd=16'h9999 -> bin=9999 (14'h270F); bcd=16'h0000 -> bin=0; both have err=0.
REQ-029 Scenario, backpressure: out_ready=0 for 10 cycles after out_valid -> bin and out_valid stay stable, in_ready=0, and a new bcd on the bus is ignored; out_ready=1 -> one transfer, then IDLE.
REQ-030 Scenario, reset mid-operation: rst_n low 2 cycles into CONV -> out_valid, bin and err are 0 immediately, no result is emitted, and the next word 16'h0042 converts to 42.
REQ-031 Scenario, illegal digit: bcd=16'h12A4 -> with BCD_CHECK_EN, err=1 and bin=0; without BCD_CHECK_EN, err=0 and bin=1304.
REQ-032 Scenario, back-to-back: in_valid held high with out_ready=1 and words 16'h0001 then 16'h0010 -> results 1 and 10, spaced 6 cycles apart.
